// File: rtl/sum_game_pkg.sv
// Shared definitions for the sum game core: FSM state codes, display codes
// and a ceiling-log2 helper for sizing counters from parameters.
package sum_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHOW      = 3'd1,
    ST_WAIT_IN   = 3'd2,
    ST_RESULT    = 3'd3,
    ST_COUNTDOWN = 3'd4,
    ST_WIN       = 3'd5,
    ST_LOSE      = 3'd6
  } game_state_t;

  localparam logic [7:0] PASS_CODE = 8'd11;
  localparam logic [7:0] WIN_CODE  = 8'd99;

  // Smallest bit count (at least 1) whose range 0..2^n-1 covers values < v.
  function automatic int clog2(input int unsigned v);
    int r;
    r = 1;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sum_game_core_bin2bcd_99.sv
// Two-digit binary to BCD conversion; inputs above 99 display as 99.
module bin2bcd_99 (
  input  logic [7:0] bin,
  output logic [3:0] tens,
  output logic [3:0] units
);

  logic [7:0] sat;

  // Saturate then split into decimal digits.
  always_comb begin
    sat   = (bin > 8'd99) ? 8'd99 : bin;
    tens  = 4'(sat / 8'd10);
    units = 4'(sat % 8'd10);
  end

endmodule

// File: rtl/sum_game_core.sv
// Mental-arithmetic game core: shows NUM_TERMS LFSR terms per round, takes the
// player's sum with a submit strobe, and walks NUM_LEVELS levels of shrinking
// display time with a countdown between levels.
module sum_game_core
  import sum_game_pkg::*;
#(
  parameter int               RND_W        = 5,
  parameter logic [RND_W-1:0] LFSR_TAPS    = 5'b10100,
  parameter logic [RND_W-1:0] LFSR_SEED    = 5'b10101,
  parameter int               NUM_TERMS    = 3,
  parameter int               NUM_LEVELS   = 4,
  parameter int               BASE_TICKS   = 6,
  parameter int               TICK_STEP    = 2,
  parameter int               MIN_TICKS    = 2,
  parameter int               INPUT_TICKS  = 10,
  parameter int               RESULT_TICKS = 5,
  parameter int               CD_START     = 3,
  parameter int               SW_W         = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic            start,
  input  logic            submit,
  input  logic [SW_W-1:0] switch,
  output logic [7:0]      disp_bin,
  output logic [3:0]      bcd_tens,
  output logic [3:0]      bcd_units,
  output logic [6:0]      led,
  output logic [2:0]      level,
  output logic [7:0]      score,
  output logic [2:0]      state_o
);

  localparam int SUM_W   = SW_W;
  localparam int T_MAX1  = (BASE_TICKS > INPUT_TICKS) ? BASE_TICKS : INPUT_TICKS;
  localparam int T_MAX2  = (RESULT_TICKS > MIN_TICKS) ? RESULT_TICKS : MIN_TICKS;
  localparam int T_MAX   = (T_MAX1 > T_MAX2) ? T_MAX1 : T_MAX2;
  localparam int TMR_W   = clog2(T_MAX + 1);
  localparam int TI_W    = clog2(NUM_TERMS);
  localparam int CD_W    = clog2(CD_START + 1);
  localparam int FULL_W  = RND_W + 2;
  localparam logic [RND_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? RND_W'(1) : LFSR_SEED;

  game_state_t       state;
  logic [RND_W-1:0]  lfsr;
  logic [RND_W-1:0]  lfsr_next;
  logic              fb;
  logic [SUM_W-1:0]  acc;
  logic [TMR_W-1:0]  timer;
  logic [TMR_W-1:0]  term_last;
  logic [TI_W-1:0]   term_idx;
  logic [CD_W-1:0]   cd;
  logic [CD_W-1:0]   cd_dec;
  logic              pass;
  logic [7:0]        term_disp;
  logic [7:0]        cd_dec_disp;
  logic [7:0]        cd_start_disp;
  logic [FULL_W-1:0] term_full;
  logic [6:0]        term_led;
  logic [7:0]        score_inc;

  function automatic logic [7:0] to_disp(input logic [31:0] v);
    return (v > 32'd99) ? 8'd99 : v[7:0];
  endfunction

  // LFSR feedback, next term value and derived display/LED images.
  always_comb begin
    fb            = ^(lfsr & LFSR_TAPS);
    lfsr_next     = {lfsr[RND_W-2:0], fb};
    term_disp     = to_disp(32'(lfsr));
    term_full     = {lfsr, 2'b00};
    cd_dec        = cd - CD_W'(1);
    cd_dec_disp   = to_disp(32'(cd_dec));
    cd_start_disp = to_disp(32'(CD_START));
    score_inc     = (score == 8'hFF) ? score : score + 8'd1;
  end

  // Term display period for the current level, as the last timer value.
  always_comb begin
    int p;
    p = BASE_TICKS - int'(level) * TICK_STEP;
    if (p < MIN_TICKS) p = MIN_TICKS;
    term_last = TMR_W'(p - 1);
  end

  // Term shown on the LEDs MSB-aligned; extra LSBs are dropped or zero padded.
  if (FULL_W >= 7) begin : g_led_trunc
    assign term_led = term_full[FULL_W-1 -: 7];
  end else begin : g_led_pad
    assign term_led = {term_full, (7 - FULL_W)'(0)};
  end

  assign state_o = state;

  // Game FSM with registered display, LED, level and score outputs.
  // Entry into SHOW (from IDLE, COUNTDOWN, WIN, LOSE) loads the first term
  // on the transition edge, so the first term is visible one cycle after start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      lfsr     <= SEED_EFF;
      level    <= '0;
      score    <= '0;
      disp_bin <= '0;
      led      <= '0;
      acc      <= '0;
      timer    <= '0;
      term_idx <= '0;
      cd       <= '0;
      pass     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_SHOW;
            term_idx <= '0;
            timer    <= '0;
            acc      <= SUM_W'(lfsr);
            disp_bin <= term_disp;
            led      <= term_led;
            lfsr     <= lfsr_next;
          end
        end

        ST_SHOW: begin
          if (tick) begin
            if (timer == term_last) begin
              timer <= '0;
              if (term_idx == TI_W'(NUM_TERMS - 1)) begin
                state    <= ST_WAIT_IN;
                disp_bin <= '0;
                led      <= '0;
              end else begin
                term_idx <= term_idx + TI_W'(1);
                acc      <= acc + SUM_W'(lfsr);
                disp_bin <= term_disp;
                led      <= term_led;
                lfsr     <= lfsr_next;
              end
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
        end

        ST_WAIT_IN: begin
          // submit takes priority over a coincident tick
          if (submit) begin
            state <= ST_RESULT;
            timer <= '0;
            pass  <= (switch == acc);
            if (switch == acc) begin
              disp_bin <= PASS_CODE;
              score    <= score_inc;
            end else begin
              disp_bin <= '0;
            end
          end else if (tick) begin
            if (timer == TMR_W'(INPUT_TICKS - 1)) begin
              state    <= ST_RESULT;
              timer    <= '0;
              pass     <= 1'b0;
              disp_bin <= '0;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
        end

        ST_RESULT: begin
          if (tick) begin
            if (timer == TMR_W'(RESULT_TICKS - 1)) begin
              timer <= '0;
              if (!pass) begin
                state    <= ST_LOSE;
                disp_bin <= '0;
              end else if (level == 3'(NUM_LEVELS - 1)) begin
                state    <= ST_WIN;
                disp_bin <= WIN_CODE;
                led      <= '1;
              end else begin
                state    <= ST_COUNTDOWN;
                cd       <= CD_W'(CD_START);
                disp_bin <= cd_start_disp;
              end
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
        end

        ST_COUNTDOWN: begin
          if (tick) begin
            if (cd <= CD_W'(1)) begin
              state    <= ST_SHOW;
              level    <= level + 3'd1;
              term_idx <= '0;
              timer    <= '0;
              acc      <= SUM_W'(lfsr);
              disp_bin <= term_disp;
              led      <= term_led;
              lfsr     <= lfsr_next;
            end else begin
              cd       <= cd_dec;
              disp_bin <= cd_dec_disp;
            end
          end
        end

        ST_WIN, ST_LOSE: begin
          if (start) begin
            state    <= ST_SHOW;
            level    <= '0;
            score    <= '0;
            term_idx <= '0;
            timer    <= '0;
            acc      <= SUM_W'(lfsr);
            disp_bin <= term_disp;
            led      <= term_led;
            lfsr     <= lfsr_next;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  bin2bcd_99 u_bcd (
    .bin   (disp_bin),
    .tens  (bcd_tens),
    .units (bcd_units)
  );

endmodule

// File: tb/tb_sum_game_core.sv
// Bench for sum_game_core: directed game scenarios plus random stimulus,
// all outputs compared every cycle against a round-level game model.
module tb_sum_game_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       submit = 1'b0;
  logic [7:0] switch = '0;
  logic [7:0] disp_bin;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_units;
  logic [6:0] led;
  logic [2:0] level;
  logic [7:0] score;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  sum_game_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .start     (start),
    .submit    (submit),
    .switch    (switch),
    .disp_bin  (disp_bin),
    .bcd_tens  (bcd_tens),
    .bcd_units (bcd_units),
    .led       (led),
    .level     (level),
    .score     (score),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  // ---------------- game model (round / phase level) ----------------
  int ph;          // 0 idle,1 show,2 wait,3 result,4 countdown,5 win,6 lose
  int ml;          // generator value
  int mlevel, mscore, mdisp, mled, macc;
  int terms_left, ticks_left, cd_val;
  bit mpass;

  function automatic int gen_next(input int v);
    return ((v * 2) % 32) + ($countones(v & 20) % 2);
  endfunction

  function automatic int show_ticks(input int lvl);
    int p;
    p = 6 - 2 * lvl;
    return (p < 2) ? 2 : p;
  endfunction

  task show_term();
    mdisp      = ml;
    mled       = (ml * 4) % 128;
    macc       = macc + ml;
    ml         = gen_next(ml);
    terms_left = terms_left - 1;
    ticks_left = show_ticks(mlevel);
  endtask

  task begin_round();
    ph         = 1;
    macc       = 0;
    terms_left = 3;
    show_term();
  endtask

  task finish_round(input bit ok);
    ph         = 3;
    mpass      = ok;
    ticks_left = 5;
    mled       = 0;
    if (ok) begin
      mdisp  = 11;
      mscore = (mscore < 255) ? mscore + 1 : 255;
    end else begin
      mdisp = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; ml = 21; mlevel = 0; mscore = 0; mdisp = 0; mled = 0;
      macc = 0; terms_left = 0; ticks_left = 0; cd_val = 0; mpass = 0;
    end else begin
      case (ph)
        0: if (start) begin_round();
        1: if (tick) begin
          ticks_left = ticks_left - 1;
          if (ticks_left == 0) begin
            if (terms_left == 0) begin
              ph = 2; mdisp = 0; mled = 0; ticks_left = 10;
            end else show_term();
          end
        end
        2: if (submit) finish_round(int'(switch) == (macc % 256));
           else if (tick) begin
             ticks_left = ticks_left - 1;
             if (ticks_left == 0) finish_round(1'b0);
           end
        3: if (tick) begin
          ticks_left = ticks_left - 1;
          if (ticks_left == 0) begin
            if (!mpass) begin ph = 6; mdisp = 0; end
            else if (mlevel == 3) begin ph = 5; mdisp = 99; mled = 127; end
            else begin ph = 4; cd_val = 3; mdisp = 3; end
          end
        end
        4: if (tick) begin
          if (cd_val == 1) begin
            mlevel = mlevel + 1;
            begin_round();
          end else begin
            cd_val = cd_val - 1;
            mdisp  = cd_val;
          end
        end
        default: if (start) begin
          mlevel = 0; mscore = 0;
          mled   = 0;
          begin_round();
        end
      endcase
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("state",  32'(state_o),   ph);
      check("disp",   32'(disp_bin),  mdisp);
      check("tens",   32'(bcd_tens),  mdisp / 10);
      check("units",  32'(bcd_units), mdisp % 10);
      check("led",    32'(led),       mled);
      check("level",  32'(level),     mlevel);
      check("score",  32'(score),     mscore);
    end
  end

  // ---------------- stimulus helpers ----------------
  task idle_cycle();
    start  = (ph == 1 || ph == 3 || ph == 4) && ($urandom_range(0, 3) == 0);
    submit = (ph != 2) && ($urandom_range(0, 3) == 0);
    if (ph != 2) switch = 8'($urandom);
    @(negedge clk);
    start  = 1'b0;
    submit = 1'b0;
  endtask

  task ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
  endtask

  task pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task do_submit(input int val);
    switch = 8'(val);
    submit = 1'b1;
    @(negedge clk);
    submit = 1'b0;
  endtask

  task play_show();
    int budget;
    budget = 100;
    while (ph == 1 && budget > 0) begin
      ticks(1);
      budget--;
    end
    check("show_ends_bounded", 32'(budget > 0), 1);
  endtask

  task pass_round();
    play_show();
    do_submit(macc);
    ticks(5);
  endtask

  task async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_state"}, 32'(state_o), 0);
    check({tag, "_disp"},  32'(disp_bin), 0);
    check({tag, "_bcd"},   32'({bcd_tens, bcd_units}), 0);
    check({tag, "_led"},   32'(led), 0);
    check({tag, "_level"}, 32'(level), 0);
    check({tag, "_score"}, 32'(score), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_state", 32'(state_o), 0);
    check("reset_disp",  32'(disp_bin), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Scenario 1: seed 10101, three terms at 6 ticks each
    pulse_start();
    check("s1_term0", 32'(disp_bin), 21);
    check("s1_led0",  32'(led), 7'h54);
    ticks(5);
    check("s1_term0_held", 32'(disp_bin), 21);
    ticks(1);
    check("s1_term1", 32'(disp_bin), 10);
    ticks(6);
    check("s1_term2", 32'(disp_bin), 20);
    ticks(6);
    check("s1_wait", 32'(state_o), 2);
    check("s1_model_acc", 32'(macc), 51);

    // Scenario 2: correct answer, countdown, level 1 at 4 ticks/term
    do_submit(51);
    check("s2_disp", 32'(disp_bin), 11);
    check("s2_score", 32'(score), 1);
    ticks(5);
    check("s2_cd3", 32'(disp_bin), 3);
    ticks(1);
    check("s2_cd2", 32'(disp_bin), 2);
    ticks(1);
    check("s2_cd1", 32'(disp_bin), 1);
    ticks(1);
    check("s2_level", 32'(level), 1);
    check("s2_term0", 32'(disp_bin), 8);
    ticks(3);
    check("s2_term0_held", 32'(disp_bin), 8);
    ticks(1);
    check("s2_term1", 32'(disp_bin), 16);
    ticks(4);
    check("s2_term2", 32'(disp_bin), 1);
    ticks(4);
    check("s2_wait", 32'(state_o), 2);
    check("s2_model_acc", 32'(macc), 25);

    // Scenario 3: wrong answer -> LOSE -> restart
    do_submit(24);
    check("s3_disp", 32'(disp_bin), 0);
    ticks(5);
    check("s3_lose", 32'(state_o), 6);
    pulse_start();
    check("s3_restart_state", 32'(state_o), 1);
    check("s3_restart_level", 32'(level), 0);
    check("s3_restart_score", 32'(score), 0);
    check("s3_restart_term", 32'(disp_bin), 2);

    // Scenario 4: submit on the 10th tick passes; pure timeout loses
    play_show();
    ticks(9);
    check("s4_still_wait", 32'(state_o), 2);
    switch = 8'(macc);
    tick   = 1'b1;
    submit = 1'b1;
    @(negedge clk);
    tick   = 1'b0;
    submit = 1'b0;
    check("s4_late_pass", 32'(disp_bin), 11);
    ticks(5);
    ticks(3);
    play_show();
    ticks(9);
    check("s4_wait_9", 32'(state_o), 2);
    ticks(1);
    check("s4_timeout", 32'(state_o), 3);
    ticks(5);
    check("s4_lose", 32'(state_o), 6);

    // Scenario 5: clear all four levels
    pulse_start();
    for (int r = 0; r < 4; r++) begin
      pass_round();
      if (r < 3) ticks(3);
    end
    check("s5_win",   32'(state_o), 5);
    check("s5_disp",  32'(disp_bin), 99);
    check("s5_led",   32'(led), 7'h7F);
    check("s5_score", 32'(score), 4);
    check("s5_bcd",   32'({bcd_tens, bcd_units}), 8'h99);

    // Scenario 6: asynchronous reset mid-SHOW and mid-COUNTDOWN
    pulse_start();
    ticks(2);
    async_reset_check("s6_show");
    pulse_start();
    check("s6_reseed", 32'(disp_bin), 21);
    pass_round();
    ticks(1);
    check("s6_in_cd", 32'(state_o), 4);
    async_reset_check("s6_cd");

    // Random play
    for (int c = 0; c < 4000; c++) begin
      tick   = ($urandom_range(0, 2) == 0);
      start  = ($urandom_range(0, 9) == 0);
      submit = ($urandom_range(0, 7) == 0);
      switch = ($urandom_range(0, 1) == 0) ? 8'(macc) : 8'($urandom);
      if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
    tick = 1'b0; start = 1'b0; submit = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
